mips_bus_arbiter: RTL

Shares the single memory-mapped bus of `mips_cpu_bus` between the CPU's instruction-fetch port and data port. Round-robin arbitration selects one requester, forwards its transaction to the bus slave, honours `waitrequest`, and returns read data with a one-cycle fixed slave read latency. It sits between the CPU core's fetch/load-store units and the external bus signals `address/read/write/waitrequest/writedata/byteenable/readdata`.

---
 rtl/mips_bus_pkg.sv | 31 +++
 rtl/mips_bus_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the fetch/data bus arbiter of mips_cpu_bus.
// Holds FSM/master encodings, the all-lanes byteenable constant and the round-robin pick.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } master_t;

    // Wide enough for any supported DW; the top slices off the lanes it needs.
    localparam logic [127:0] BE_ALL = '1;

    // Sole requester wins; on a tie the master that was not served last wins.
    function automatic master_t rr_pick(input logic f_req, input logic d_req, input master_t last);
        master_t pick;
        pick = FETCH;
        if (f_req && d_req) begin
            pick = (last == FETCH) ? DATA : FETCH;
        end else if (d_req) begin
            pick = DATA;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped bus between the CPU fetch and data ports.
// Honours slave waitrequest and returns read data one cycle after read acceptance.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   i_address,
    input  logic            i_read,
    output logic            i_waitrequest,
    output logic [DW-1:0]   i_readdata,

    input  logic [AW-1:0]   d_address,
    input  logic            d_read,
    input  logic            d_write,
    input  logic [DW-1:0]   d_writedata,
    input  logic [DW/8-1:0] d_byteenable,
    output logic            d_waitrequest,
    output logic [DW-1:0]   d_readdata,

    output logic [AW-1:0]   address,
    output logic            read,
    output logic            write,
    output logic [DW-1:0]   writedata,
    output logic [DW/8-1:0] byteenable,
    input  logic            waitrequest,
    input  logic [DW-1:0]   readdata
);

    localparam int unsigned BW = DW / 8;

    arb_state_t state_q, state_d;
    master_t    grant_q, grant_d;
    master_t    last_q,  last_d;

    logic d_req;
    logic req_g;
    logic i_done;
    logic d_done;

    assign d_req = d_read | d_write;
    assign req_g = (grant_q == FETCH) ? i_read : d_req;

    // State, grant and round-robin history; last starts at DATA so fetch wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= FETCH;
            last_q  <= DATA;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next state plus bus/master muxing; all bus outputs decode from state so reset clears them at once.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        i_readdata = '0;
        d_readdata = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    grant_d = rr_pick(i_read, d_req, last_q);
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!req_g) begin
                    // Master withdrew its request: drop the transaction without completing it.
                    state_d = IDLE;
                end else if (grant_q == FETCH) begin
                    address    = i_address;
                    read       = 1'b1;
                    byteenable = BE_ALL[BW-1:0];
                    if (!waitrequest) begin
                        state_d = RDATA;
                    end
                end else begin
                    address    = d_address;
                    write      = d_write;
                    read       = ~d_write;
                    writedata  = d_write ? d_writedata : '0;
                    byteenable = d_byteenable;
                    if (!waitrequest) begin
                        if (d_write) begin
                            d_done  = 1'b1;
                            last_d  = DATA;
                            state_d = IDLE;
                        end else begin
                            state_d = RDATA;
                        end
                    end
                end
            end

            RDATA: begin
                if (grant_q == FETCH) begin
                    i_readdata = readdata;
                    i_done     = 1'b1;
                end else begin
                    d_readdata = readdata;
                    d_done     = 1'b1;
                end
                last_d  = grant_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_waitrequest = i_read & ~i_done;
    assign d_waitrequest = d_req & ~d_done;

endmodule
